pending_encoder_8x3: RTL and testbench

//  Collects single-cycle event pulses on 8 request lines into a pending set.

---
 rtl/enc_pkg.sv | 19 +
 rtl/priority_encoder_8x3.sv | 42 ++++
 rtl/pending_encoder_8x3.sv | 93 +++++++++
 tb/tb_pending_encoder_8x3.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths, FSM state encoding and one-hot helper for the pending encoder.
package enc_pkg;

  localparam int N_IN  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  function automatic logic [N_IN-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_IN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_encoder_8x3.sv
// Combinational 8->3 priority encoder with a movable search start.
// ASCEND=1: first set bit at or above start, wrapping; ASCEND=0: first set bit at or below start, wrapping.
module priority_encoder_8x3
  import enc_pkg::*;
#(
  parameter bit ASCEND = 1'b0
) (
  input  logic [N_IN-1:0]  vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_IN-1:0] win;
  logic [N_IN-1:0] cand;

  // Search the window on the start side first; if empty, the wrapped part is the whole vector.
  always_comb begin
    win = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (ASCEND) win[i] = (IDX_W'(i) >= start);
      else        win[i] = (IDX_W'(i) <= start);
    end
    cand = (|(vec & win)) ? (vec & win) : vec;
  end

  always_comb begin
    idx = '0;
    if (ASCEND) begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (cand[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (cand[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/pending_encoder_8x3.sv
// Captures 8 event pulses into a pending set and presents one encoded index per handshake.
// Latency 1 cycle req->code; code/valid hold while valid & ~ready, one event accepted per cycle.
module pending_encoder_8x3
  import enc_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  output logic [IDX_W-1:0] code,
  output logic             valid,
  input  logic             ready,
  output logic [N_IN-1:0]  pending,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] code_q, code_d;
  logic [N_IN-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;

  logic [N_IN-1:0]  merge;
  logic [IDX_W-1:0] sel;
  logic             merge_any;
  logic [IDX_W-1:0] search_start;
  logic             load;

  // New requests bypass the pending register so an idle encoder presents them next edge.
  assign merge        = pending_q | req;
  assign search_start = (RR != 0) ? rr_ptr_q : IDX_W'(N_IN - 1);

  priority_encoder_8x3 #(
    .ASCEND (RR != 0)
  ) u_prio (
    .vec   (merge),
    .start (search_start),
    .idx   (sel),
    .any   (merge_any)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pending_d  = merge;
    rr_ptr_d   = rr_ptr_q;
    load       = 1'b0;
    overflow_d = |(req & pending_q);

    case (state_q)
      IDLE: begin
        if (merge_any) load = 1'b1;
      end
      SHOW: begin
        if (ready) begin
          if (merge_any) load = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = SHOW;
      code_d    = sel;
      pending_d = merge & ~onehot8(sel);
      rr_ptr_d  = sel + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign code     = code_q;
  assign valid    = (state_q == SHOW);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pending_encoder_8x3.sv
// Directed bench: fixed-priority (RR=0) and round-robin (RR=1) instances share stimulus.
module tb_pending_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;

  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;
  logic       ovf0, ovf1;

  int n_checks = 0;
  int n_errors = 0;

  pending_encoder_8x3 #(.RR(0)) dut_fp (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .code     (code0),
    .valid    (valid0),
    .ready    (ready),
    .pending  (pend0),
    .overflow (ovf0)
  );

  pending_encoder_8x3 #(.RR(1)) dut_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .code     (code1),
    .valid    (valid1),
    .ready    (ready),
    .pending  (pend1),
    .overflow (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fp(input string tag, input logic [2:0] c, input logic v, input logic [7:0] p, input logic o);
    chk({tag, ".code"},  8'(code0), 8'(c));
    chk({tag, ".valid"}, 8'(valid0), 8'(v));
    chk({tag, ".pend"},  pend0, p);
    chk({tag, ".ovf"},   8'(ovf0), 8'(o));
  endtask

  task automatic chk_rr(input string tag, input logic [2:0] c, input logic v, input logic [7:0] p);
    chk({tag, ".code"},  8'(code1), 8'(c));
    chk({tag, ".valid"}, 8'(valid1), 8'(v));
    chk({tag, ".pend"},  pend1, p);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    ready = 1'b0;
    #2;

    // 1: reset ignores req
    repeat (3) step();
    chk_fp("rst_fp", 3'd0, 1'b0, 8'h00, 1'b0);
    chk_rr("rst_rr", 3'd0, 1'b0, 8'h00);
    chk("rst_rr.ovf", 8'(ovf1), 8'h00);
    rst_n = 1'b1;
    req   = 8'h00;
    step();
    chk_fp("rel_fp", 3'd0, 1'b0, 8'h00, 1'b0);

    // 2: fixed priority drains 7,4,1
    req = 8'b1001_0010; ready = 1'b1;
    step();
    chk_fp("fp_a", 3'd7, 1'b1, 8'h12, 1'b0);
    req = 8'h00;
    step();
    chk_fp("fp_b", 3'd4, 1'b1, 8'h02, 1'b0);
    step();
    chk_fp("fp_c", 3'd1, 1'b1, 8'h00, 1'b0);
    step();
    chk("fp_end.valid", 8'(valid0), 8'h00);

    // 3: hold under backpressure
    req = 8'h01; ready = 1'b0;
    step();
    chk_fp("hold_0", 3'd0, 1'b1, 8'h00, 1'b0);
    req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold.code", 8'(code0), 8'h00);
      chk("hold.valid", 8'(valid0), 8'h01);
    end
    ready = 1'b1;
    step();
    chk("hold_rel.valid", 8'(valid0), 8'h00);

    // 4: duplicate on pending bit 3 flags overflow once, 3 emitted once
    ready = 1'b0; req = 8'h88;
    step();
    chk_fp("ovf_a", 3'd7, 1'b1, 8'h08, 1'b0);
    req = 8'h08;
    step();
    chk_fp("ovf_b", 3'd7, 1'b1, 8'h08, 1'b1);
    req = 8'h00;
    step();
    chk_fp("ovf_c", 3'd7, 1'b1, 8'h08, 1'b0);
    ready = 1'b1;
    step();
    chk_fp("ovf_d", 3'd3, 1'b1, 8'h00, 1'b0);
    step();
    chk_fp("ovf_e", 3'd3, 1'b0, 8'h00, 1'b0);

    // 5: round robin ascending with pointer wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF; ready = 1'b1;
    step();
    chk_rr("rr_0", 3'd0, 1'b1, 8'hFE);
    req = 8'h00;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("rr_seq.code", 8'(code1), 8'(i));
      chk("rr_seq.valid", 8'(valid1), 8'h01);
    end
    chk("rr_seq.pend", pend1, 8'h00);
    req = 8'h81;
    step();
    chk_rr("rr_wrap_a", 3'd0, 1'b1, 8'h80);
    req = 8'h00;
    step();
    chk_rr("rr_wrap_b", 3'd7, 1'b1, 8'h00);
    step();
    chk("rr_wrap_end.valid", 8'(valid1), 8'h00);
    chk("fp_idle.valid", 8'(valid0), 8'h00);

    // 6: mid-stream reset discards presented and pending events
    ready = 1'b0; req = 8'h8C;
    step();
    chk_fp("mid_a", 3'd7, 1'b1, 8'h0C, 1'b0);
    rst_n = 1'b0; req = 8'h10;
    step();
    chk_fp("mid_rst", 3'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1; req = 8'h00; ready = 1'b1;
    step();
    chk_fp("mid_rel", 3'd0, 1'b0, 8'h00, 1'b0);
    step();
    chk("mid_rel2.valid", 8'(valid0), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
